// File: rtl/titan_pkg.sv
// Shared types and constants for the titan SPI front end.
package titan_pkg;

    localparam int SPI_BYTE_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_e;

    // Synchronisers power up as if the bus were idle: SCK low, deselected.
    localparam logic SCK_RST_VAL  = 1'b0;
    localparam logic CS_N_RST_VAL = 1'b1;
    localparam logic MOSI_RST_VAL = 1'b0;

endpackage

// File: rtl/sync_ff.sv
// N-stage flip-flop synchroniser for one asynchronous input bit.
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target: oversamples the pins in clk_i, assembles received bytes
// and shifts the handler's reply byte out on MISO.
module spi_peripheral
    import titan_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_sck_i,
    input  logic                  spi_cs_n_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    output logic                  spi_rx_valid_o,
    output logic [SPI_BYTE_W-1:0] spi_rx_byte_o,
    input  logic [SPI_BYTE_W-1:0] spi_tx_byte_i
);

    logic sck_s;
    logic cs_n_s;
    logic mosi_s;

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_RST_VAL)) u_sync_sck (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sck_i), .q_o(sck_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(CS_N_RST_VAL)) u_sync_cs_n (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_cs_n_i), .q_o(cs_n_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_RST_VAL)) u_sync_mosi (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_mosi_i), .q_o(mosi_s)
    );

    logic sck_prev_q;
    logic cs_n_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_prev_q  <= SCK_RST_VAL;
            cs_n_prev_q <= CS_N_RST_VAL;
        end else begin
            sck_prev_q  <= sck_s;
            cs_n_prev_q <= cs_n_s;
        end
    end

    logic sck_rise;
    logic sck_fall;
    logic cs_fall;

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_n_s & cs_n_prev_q;

    spi_state_e               state_q,   state_d;
    logic [SPI_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-1:0]    rx_shift_q, rx_shift_d;
    logic [SPI_BYTE_W-1:0]    tx_shift_q, tx_shift_d;
    logic [SPI_BYTE_W-1:0]    rx_byte_q, rx_byte_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     reload_q,  reload_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            reload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            reload_q   <= reload_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = 1'b0;
        reload_d   = reload_q;

        case (state_q)
            IDLE: begin
                // SCK edges are ignored here, so a coincident sck_fall cannot disturb the load.
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = '0;
                    tx_shift_d = spi_tx_byte_i;
                    reload_d   = 1'b0;
                end
            end
            ACTIVE: begin
                if (cs_n_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                end else begin
                    if (sck_rise) begin
                        rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == '1) begin
                            rx_byte_d  = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
                            rx_valid_d = 1'b1;
                            reload_d   = 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        if (reload_q) begin
                            tx_shift_d = spi_tx_byte_i;
                            reload_d   = 1'b0;
                        end else begin
                            tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_miso_o     = tx_shift_q[SPI_BYTE_W-1];
    assign spi_miso_oe_o  = (state_q == ACTIVE);
    assign spi_rx_valid_o = rx_valid_q;
    assign spi_rx_byte_o  = rx_byte_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a host model drives mode-0 transfers while
// a strobe monitor checks received bytes against a queue of expected values.
module tb_spi_peripheral;

    localparam int HALF  = 5;
    localparam int SETUP = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic [7:0] tx_byte;
    logic       miso;
    logic       miso_oe;
    logic       rx_valid;
    logic [7:0] rx_byte;

    spi_peripheral #(.SYNC_STAGES(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .spi_sck_i     (sck),
        .spi_cs_n_i    (cs_n),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (miso_oe),
        .spi_rx_valid_o(rx_valid),
        .spi_rx_byte_o (rx_byte),
        .spi_tx_byte_i (tx_byte)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] rx_exp[$];
    bit         echo_en = 1'b0;
    logic [7:0] last_rx = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every strobe must match the oldest outstanding byte.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (rx_exp.size() == 0) begin
                check_int("unexpected_strobe", rx_exp.size(), 1);
            end else begin
                logic [7:0] e;
                e = rx_exp.pop_front();
                check("rx_byte", rx_byte, e);
                $display("rx strobe: byte %h expected %h", rx_byte, e);
                last_rx = e;
                if (echo_en) tx_byte = e + 8'h01;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic select_host();
        cs_n = 1'b0;
        wait_clk(SETUP);
    endtask

    task automatic deselect_host();
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && rx_exp.size() != 0; k++) wait_clk(1);
        check_int(tag, rx_exp.size(), 0);
    endtask

    // Mode-0 host: MOSI changes while SCK is low, MISO sampled at each rising SCK.
    task automatic xfer(input logic [7:0] mo, input int nbits, input logic [7:0] exp_mi);
        logic [7:0] mi;
        logic       early;
        mi = 8'h00;
        if (nbits == 8) rx_exp.push_back(mo);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = mo[i];
            wait_clk(HALF - 1);
            early = miso;
            wait_clk(1);
            if (nbits == 8) check("miso_stable", {7'b0, miso}, {7'b0, early});
            mi[i] = miso;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
        if (nbits == 8) begin
            check("miso_byte", mi, exp_mi);
            $display("xfer: mosi %h miso %h expected %h", mo, mi, exp_mi);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] exp_mi;

        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_byte = 8'h00;
        #3;
        check("rst_miso", {7'b0, miso}, 8'h00);
        check("rst_oe", {7'b0, miso_oe}, 8'h00);
        check("rst_valid", {7'b0, rx_valid}, 8'h00);
        check("rst_rx_byte", rx_byte, 8'h00);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);

        // Single byte
        tx_byte = 8'h3C;
        select_host();
        check("oe_selected", {7'b0, miso_oe}, 8'h01);
        xfer(8'hA5, 8, 8'h3C);
        deselect_host();
        drain("single_drain");
        check("oe_deselected", {7'b0, miso_oe}, 8'h00);

        // Three-byte burst with echo
        tx_byte = 8'h55;
        echo_en = 1'b1;
        select_host();
        xfer(8'h01, 8, 8'h55);
        xfer(8'h12, 8, 8'h02);
        xfer(8'h34, 8, 8'h13);
        deselect_host();
        drain("burst_drain");
        echo_en = 1'b0;

        // Abort after 5 bits, then reselect
        tx_byte = 8'h77;
        select_host();
        xfer(8'hC3, 5, 8'h00);
        deselect_host();
        wait_clk(10);
        check("abort_rx_hold", rx_byte, last_rx);
        drain("abort_drain");
        tx_byte = 8'h88;
        select_host();
        xfer(8'hFF, 8, 8'h88);
        deselect_host();
        drain("reselect_drain");

        // Reset mid-byte
        tx_byte = 8'h96;
        select_host();
        xfer(8'hF0, 3, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_miso", {7'b0, miso}, 8'h00);
        check("midrst_oe", {7'b0, miso_oe}, 8'h00);
        check("midrst_valid", {7'b0, rx_valid}, 8'h00);
        check("midrst_rx_byte", rx_byte, 8'h00);
        cs_n = 1'b1;
        sck  = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        last_rx = 8'h00;
        wait_clk(4);

        // SCK activity while deselected
        mosi = 1'b1;
        for (int e = 0; e < 20; e++) begin
            sck = ~sck;
            wait_clk(HALF);
            check("idle_oe", {7'b0, miso_oe}, 8'h00);
        end
        check("idle_rx_byte", rx_byte, 8'h00);
        drain("idle_drain");

        // Fresh select after reset works
        tx_byte = 8'h5A;
        select_host();
        xfer(8'hC3, 8, 8'h5A);
        deselect_host();
        drain("post_reset_drain");

        // Minimum timing, random bytes with echo
        tx_byte = 8'($urandom_range(0, 255));
        exp_mi = tx_byte;
        echo_en = 1'b1;
        select_host();
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom_range(0, 255));
            xfer(b, 8, exp_mi);
            exp_mi = b + 8'h01;
        end
        deselect_host();
        drain("random_drain");
        echo_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
